// File: rtl/dac_wave_player_if.sv
// rtl/dac_wave_player_if.sv - Control, BRAM read port and DAC output bundle for dac_wave_player
interface dac_wave_player_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 10,
  parameter int DIV_W  = 16
);
  logic              start;
  logic              stop;
  logic              loop_en;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] end_addr;
  logic [DIV_W-1:0]  rate_div;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_dout;
  logic [DATA_W-1:0] dac_data;
  logic              dac_strobe;
  logic              busy;
  logic              done;

  // System side: host controls plus the BRAM data return
  modport master (
    output start, stop, loop_en, start_addr, end_addr, rate_div, bram_dout,
    input  bram_addr, dac_data, dac_strobe, busy, done
  );

  // Player side
  modport slave (
    input  start, stop, loop_en, start_addr, end_addr, rate_div, bram_dout,
    output bram_addr, dac_data, dac_strobe, busy, done
  );
endinterface

// File: rtl/dac_wave_player.sv
// rtl/dac_wave_player.sv - BRAM-to-DAC waveform playback sequencer
module dac_wave_player #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 10,
  parameter int DIV_W  = 16
) (
  input  logic            clka,
  input  logic            rst_n,
  dac_wave_player_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              loop_q, loop_d;
  logic [ADDR_W-1:0] start_addr_q, start_addr_d;
  logic [ADDR_W-1:0] end_addr_q, end_addr_d;
  logic [DIV_W-1:0]  rdiv_q, rdiv_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic [DATA_W-1:0] dac_data_q, dac_data_d;
  logic              dac_strobe_q, dac_strobe_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Next-state logic: config latch on start, emission pacing and address sequencing
  always_comb begin
    state_d      = state_q;
    loop_d       = loop_q;
    start_addr_d = start_addr_q;
    end_addr_d   = end_addr_q;
    rdiv_d       = rdiv_q;
    cnt_d        = cnt_q;
    bram_addr_d  = bram_addr_q;
    dac_data_d   = dac_data_q;
    dac_strobe_d = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          loop_d       = bus.loop_en;
          start_addr_d = bus.start_addr;
          end_addr_d   = bus.end_addr;
          // A zero divider would outrun the one-cycle BRAM latency
          rdiv_d       = (bus.rate_div == '0) ? DIV_W'(1) : bus.rate_div;
          bram_addr_d  = bus.start_addr;
          busy_d       = 1'b1;
          state_d      = PRIME;
        end
      end

      PRIME: begin
        if (bus.stop) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        if (bus.stop) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DIV_W'(1);
        end else begin
          dac_data_d   = bus.bram_dout;
          dac_strobe_d = 1'b1;
          // Reload with rdiv so that emissions land rdiv+1 clocks apart
          cnt_d        = rdiv_q;
          if (bram_addr_q != end_addr_q) begin
            bram_addr_d = bram_addr_q + ADDR_W'(1);
          end else if (loop_q) begin
            bram_addr_d = start_addr_q;
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clka) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      loop_q       <= 1'b0;
      start_addr_q <= '0;
      end_addr_q   <= '0;
      rdiv_q       <= '0;
      cnt_q        <= '0;
      bram_addr_q  <= '0;
      dac_data_q   <= '0;
      dac_strobe_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      loop_q       <= loop_d;
      start_addr_q <= start_addr_d;
      end_addr_q   <= end_addr_d;
      rdiv_q       <= rdiv_d;
      cnt_q        <= cnt_d;
      bram_addr_q  <= bram_addr_d;
      dac_data_q   <= dac_data_d;
      dac_strobe_q <= dac_strobe_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.bram_addr  = bram_addr_q;
  assign bus.dac_data   = dac_data_q;
  assign bus.dac_strobe = dac_strobe_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
